conv2d_stream: RTL

Parametrised streaming 2-D convolution engine; successor to the fixed 3x3/32-bit convolve datapath.
- Loads a KxK signed kernel, then accepts a raster pixel stream over valid/ready and emits valid-window results over valid/ready.
- Image width and height are runtime-configurable, with full backpressure.
- Sits behind the wishbone/LA glue in user_proj_conv, replacing shift_register, kernel_mem and multiplier.

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv2d_line_buf.sv | 51 +++++
 rtl/conv2d_stream.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the streaming convolution engine.
// Used by conv2d_stream and its line buffers.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN
  } state_e;

  function automatic int min_acc_w(
    input int data_w,
    input int coef_w,
    input int k
  );
    return data_w + coef_w + 2 * $clog2(k) + 1;
  endfunction

  // Clamp a signed value into the unsigned range [0, 2^dw-1].
  function automatic logic [63:0] sat_u(
    input logic signed [63:0] v,
    input int dw
  );
    logic signed [63:0] mx;
    mx = (64'sd1 <<< dw) - 64'sd1;
    if (v < 64'sd0) return '0;
    if (v > mx) return mx;
    return v;
  endfunction

endpackage

// File: rtl/conv2d_line_buf.sv
// conv2d_line_buf: circular line delay of runtime length len.
// dout is the sample written len enabled cycles earlier.
module conv2d_line_buf
  import conv_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_IMG_W = 128,
  parameter int DIM_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DIM_W-1:0]  len,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int AW = $clog2(MAX_IMG_W);

  logic [DATA_W-1:0] mem [MAX_IMG_W];
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              wrap;

  assign wrap = (32'(ptr_q) + 32'd1) >= 32'(len);
  assign dout = mem[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (en) begin
      ptr_d = wrap ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK convolution over a raster pixel stream.
// Kernel load, line-buffered window, 3-stage multiply/add/saturate pipe.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int COEF_W      = 8,
  parameter int ACC_W       = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int MAX_IMG_W   = 128,
  parameter int DIM_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_img_w,
  input  logic [DIM_W-1:0]  cfg_img_h,
  input  logic [4:0]        cfg_shift,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  input  logic              kern_valid,
  input  logic [COEF_W-1:0] kern_data,
  output logic              kern_ready,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int K  = KERNEL_SIZE;
  localparam int KK = K * K;
  localparam int KW = $clog2(KK);
  localparam int PW = DATA_W + COEF_W + 1;
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  state_e state_q, state_d;

  logic [DIM_W-1:0] w_q, w_d;
  logic [DIM_W-1:0] h_q, h_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [4:0]       shift_q, shift_d;
  logic [KW-1:0]    kidx_q, kidx_d;
  logic             cfg_err_q, cfg_err_d;

  logic signed [COEF_W-1:0] coef_q [KK];
  logic signed [COEF_W-1:0] coef_d [KK];

  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] win_d [K][K];
  logic [DATA_W-1:0] tap [K];
  logic [DATA_W-1:0] lb_out [K-1];

  logic signed [PW-1:0]    prod_q [KK];
  logic signed [PW-1:0]    prod_d [KK];
  logic signed [ACC_W-1:0] sum_q, sum_d;

  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic v3_q, v3_d;
  logic [DATA_W-1:0] out_q, out_d;

  logic stall;
  logic en;
  logic legal;
  logic start_ok;
  logic kern_fire;
  logic pix_fire;
  logic row_end;
  logic last_pix;
  logic win_ok;
  logic drained;

  assign stall     = v3_q && !out_ready;
  assign en        = !stall;
  assign kern_ready = (state_q == LOAD);
  assign pix_ready = (state_q == STREAM) && !stall;
  assign kern_fire = kern_valid && kern_ready;
  assign pix_fire  = pix_valid && pix_ready;

  assign legal = (32'(cfg_img_w) >= K)
              && (32'(cfg_img_w) <= MAX_IMG_W)
              && (32'(cfg_img_h) >= K);
  assign start_ok = (state_q == IDLE) && start && legal;

  assign row_end  = (col_q == w_q - ONE);
  assign last_pix = row_end && (row_q == h_q - ONE);
  assign win_ok   = (32'(row_q) >= K - 1) && (32'(col_q) >= K - 1);
  assign drained  = !v1_q && !v2_q && (!v3_q || out_ready);

  assign busy      = (state_q != IDLE);
  assign cfg_err   = cfg_err_q;
  assign out_valid = v3_q;
  assign out_data  = out_q;

  for (genvar m = 0; m < K - 1; m++) begin : g_lb
    logic [DATA_W-1:0] din;
    if (m == 0) begin : g_first
      assign din = pix_data;
    end else begin : g_chain
      assign din = lb_out[m-1];
    end
    conv2d_line_buf #(
      .DATA_W    (DATA_W),
      .MAX_IMG_W (MAX_IMG_W),
      .DIM_W     (DIM_W)
    ) u_lb (
      .clk   (clk),
      .reset (reset),
      .clr   (start_ok),
      .en    (pix_fire),
      .len   (w_q),
      .din   (din),
      .dout  (lb_out[m])
    );
  end

  // Column of taps: bottom row is the live pixel, rows above come from
  // progressively older lines.
  always_comb begin
    tap[K-1] = pix_data;
    for (int m = 1; m < K; m++) begin
      tap[K-1-m] = lb_out[m-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    shift_d   = shift_q;
    col_d     = col_q;
    row_d     = row_q;
    kidx_d    = kidx_q;
    cfg_err_d = cfg_err_q;
    coef_d    = coef_q;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            state_d   = LOAD;
            w_d       = cfg_img_w;
            h_d       = cfg_img_h;
            shift_d   = cfg_shift;
            col_d     = '0;
            row_d     = '0;
            kidx_d    = '0;
            cfg_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (kern_fire) begin
          coef_d[kidx_q] = kern_data;
          kidx_d = kidx_q + KW'(1);
          if (32'(kidx_q) == KK - 1) state_d = STREAM;
        end
      end
      STREAM: begin
        if (pix_fire) begin
          if (row_end) begin
            col_d = '0;
            row_d = row_q + ONE;
          end else begin
            col_d = col_q + ONE;
          end
          if (last_pix) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      shift_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      kidx_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      shift_q   <= shift_d;
      col_q     <= col_d;
      row_q     <= row_d;
      kidx_q    <= kidx_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Stage 1 multiplies the window as it will look after this pixel lands.
  always_comb begin
    win_d = win_q;
    if (pix_fire) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
        win_d[i][K-1] = tap[i];
      end
    end
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        prod_d[i*K+j] = PW'($signed({1'b0, win_d[i][j]}))
                      * PW'(coef_q[i*K+j]);
      end
    end
    sum_d = '0;
    for (int n = 0; n < KK; n++) begin
      sum_d = sum_d + ACC_W'(prod_q[n]);
    end
    v1_d  = pix_fire && win_ok;
    v2_d  = v1_q;
    v3_d  = v2_q;
    out_d = v2_q
          ? DATA_W'(sat_u(64'(sum_q >>> shift_q), DATA_W))
          : out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      out_q <= '0;
    end else if (en) begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      out_q <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    coef_q <= coef_d;
    win_q  <= win_d;
    if (en) begin
      prod_q <= prod_d;
      sum_q  <= sum_d;
    end
  end

endmodule
